// File: rtl/dp_ctrl_pkg.sv
// Shared definitions for the accumulate-job sequencer: state encoding and strobe layout.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package dp_ctrl_pkg;

    // Six legal states in a 3-bit register; encodings 6 and 7 are unreachable.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_A  = 3'd1,
        S_MOVE_AB = 3'd2,
        S_ADD     = 3'd3,
        S_WRITE_B = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Bit positions inside the 6-bit control vector.
    localparam int CTL_RAIN  = 0;
    localparam int CTL_RBIN  = 1;
    localparam int CTL_RZIN  = 2;
    localparam int CTL_RAOUT = 3;
    localparam int CTL_RBOUT = 4;
    localparam int CTL_RZOUT = 5;
    localparam int CTL_W     = 6;

    // Register-load / bus-drive strobes for a state. At most one *out bit is
    // ever set, so the bus always has a single driver; unknown encodings drive nothing.
    function automatic logic [CTL_W-1:0] ctl_decode(input state_t st);
        logic [CTL_W-1:0] c;
        c = '0;
        case (st)
            S_LOAD_A: begin
                c[CTL_RAIN] = 1'b1;
            end
            S_MOVE_AB: begin
                c[CTL_RAOUT] = 1'b1;
                c[CTL_RBIN]  = 1'b1;
            end
            S_ADD: begin
                c[CTL_RBOUT] = 1'b1;
                c[CTL_RZIN]  = 1'b1;
            end
            S_WRITE_B: begin
                c[CTL_RZOUT] = 1'b1;
                c[CTL_RBIN]  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Job handshake and datapath strobe bundle between a job requester and the sequencer.
// Latency: n/a (wires only).
// Backpressure: start is only honoured while busy is low; requests during busy are dropped.
// Ports: start/count (request), busy/done (status), RAin/RBin/RZin (loads), RAout/RBout/RZout (bus drive).
interface datapath_sequencer_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             RAin;
    logic             RBin;
    logic             RZin;
    logic             RAout;
    logic             RBout;
    logic             RZout;

    // Sequencer side.
    modport slave (
        input  start, count,
        output busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );

    // Requester / datapath side.
    modport master (
        output start, count,
        input  busy, done, RAin, RBin, RZin, RAout, RBout, RZout
    );
endinterface

// File: rtl/seq_loop_counter.sv
// Remaining-iteration counter for the accumulate loop.
// Latency: load/decrement visible the cycle after the edge; flags are combinational from the count.
// Backpressure: none; decrement saturates at zero so the count can never wrap.
// Ports: clock, clear (sync active-low), load/load_val, dec, is_zero, is_one.
module seq_loop_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_zero,
    output logic             is_one
);
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clock) begin
        if (!clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (dec && (remaining != '0)) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    assign is_zero = (remaining == '0);
    assign is_one  = (remaining == CNT_W'(1));
endmodule

// File: rtl/datapath_sequencer.sv
// Moore sequencer driving the RA/RB/RZ datapath: RA<-imm, RB<-RA, then count x {RZ<-A+RB; RB<-RZ}.
// Latency: start accepted at edge 0, done pulses in cycle 3+2*count, IDLE the cycle after.
// Backpressure: start is ignored (not queued) while busy; count is only sampled with an accepted start.
// Ports: clock, clear (sync active-low), dif (slave modport: start/count in, busy/done/strobes out).
module datapath_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    datapath_sequencer_if.slave  dif
);
    state_t           state;
    state_t           state_nxt;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             cnt_one;
    logic [CTL_W-1:0] ctl;

    seq_loop_counter #(.CNT_W(CNT_W)) u_cnt (
        .clock    (clock),
        .clear    (clear),
        .load     (cnt_load),
        .load_val (dif.count),
        .dec      (cnt_dec),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            S_IDLE: begin
                if (dif.start) begin
                    state_nxt = S_LOAD_A;
                    cnt_load  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD_A:  state_nxt = S_MOVE_AB;
            // count==0 skips the loop entirely so the counter is never decremented from zero.
            S_MOVE_AB: state_nxt = cnt_zero ? S_DONE : S_ADD;
            S_ADD:     state_nxt = S_WRITE_B;
            S_WRITE_B: begin
                cnt_dec   = 1'b1;
                state_nxt = cnt_one ? S_DONE : S_ADD;
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Outputs depend on the state register only.
    always_comb begin
        ctl      = ctl_decode(state);
        dif.busy = 1'b0;
        dif.done = 1'b0;
        case (state)
            S_LOAD_A, S_MOVE_AB, S_ADD, S_WRITE_B: dif.busy = 1'b1;
            S_DONE: begin
                dif.busy = 1'b1;
                dif.done = 1'b1;
            end
            default: begin
                dif.busy = 1'b0;
                dif.done = 1'b0;
            end
        endcase
    end

    assign dif.RAin  = ctl[CTL_RAIN];
    assign dif.RBin  = ctl[CTL_RBIN];
    assign dif.RZin  = ctl[CTL_RZIN];
    assign dif.RAout = ctl[CTL_RAOUT];
    assign dif.RBout = ctl[CTL_RBOUT];
    assign dif.RZout = ctl[CTL_RZOUT];
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed and randomised bench for datapath_sequencer with a behavioural RA/RB/RZ datapath.
// Latency: n/a.
// Backpressure: n/a.
module tb_datapath_sequencer;
    // Expected {busy, done, RZout, RBout, RAout, RZin, RBin, RAin} per state.
    localparam logic [7:0] V_IDLE  = 8'b00_000000;
    localparam logic [7:0] V_LOADA = 8'b10_000001;
    localparam logic [7:0] V_MOVE  = 8'b10_001010;
    localparam logic [7:0] V_ADD   = 8'b10_010100;
    localparam logic [7:0] V_WB    = 8'b10_100010;
    localparam logic [7:0] V_DONE  = 8'b11_000000;

    logic clock;
    logic clear;
    int   checks;
    int   errors;

    datapath_sequencer_if #(.CNT_W(4)) dif ();

    datapath_sequencer #(.CNT_W(4)) dut (
        .clock (clock),
        .clear (clear),
        .dif   (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural model of the existing 8-bit datapath, driven by the strobes.
    logic [7:0] ra, rb, rz, imm, a, bus;
    always_comb begin
        bus = 8'h00;
        if (dif.RAout)      bus = ra;
        else if (dif.RBout) bus = rb;
        else if (dif.RZout) bus = rz;
    end
    always_ff @(posedge clock) begin
        if (dif.RAin) ra <= imm;
        if (dif.RBin) rb <= bus;
        if (dif.RZin) rz <= a + bus;
    end

    function automatic logic [7:0] obs_vec();
        return {dif.busy, dif.done, dif.RZout, dif.RBout, dif.RAout,
                dif.RZin, dif.RBin, dif.RAin};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issues one job from an IDLE cycle and checks every cycle up to and including
    // the IDLE cycle after DONE. Returns with the bench positioned in that IDLE cycle.
    task automatic run_job(input string tag, input logic [7:0] imm_v, input logic [7:0] a_v,
                           input int cnt, input bit hold);
        int         total;
        int         t;
        logic [7:0] exp_rb;
        logic [7:0] exp_v;
        imm       = imm_v;
        a         = a_v;
        dif.count = 4'(cnt);
        dif.start = 1'b1;
        step();
        if (!hold) dif.start = 1'b0;
        dif.count = ~4'(cnt);   // must have no effect once the job is running
        total  = 3 + 2 * cnt;
        t      = int'(imm_v) + cnt * int'(a_v);
        exp_rb = t[7:0];
        for (int k = 1; k <= total; k++) begin
            if (k == 1)          exp_v = V_LOADA;
            else if (k == 2)     exp_v = V_MOVE;
            else if (k == total) exp_v = V_DONE;
            else if (k % 2 == 1) exp_v = V_ADD;
            else                 exp_v = V_WB;
            chk($sformatf("%s_c%0d", tag, k), 32'(obs_vec()), 32'(exp_v));
            if (k == total) chk({tag, "_rb"}, 32'(rb), 32'(exp_rb));
            step();
        end
        chk({tag, "_idle"}, 32'(obs_vec()), 32'(V_IDLE));
    endtask

    int         ref_left;
    bit         st_s;
    bit         cl_s;
    logic [3:0] cn_s;
    logic [7:0] ref_rb;
    int         tt;

    initial begin
        checks    = 0;
        errors    = 0;
        clear     = 1'b0;
        dif.start = 1'b0;
        dif.count = '0;
        imm       = '0;
        a         = '0;
        step();
        step();
        chk("reset_vec", 32'(obs_vec()), 32'(V_IDLE));
        clear = 1'b1;
        step();
        chk("idle_after_reset", 32'(obs_vec()), 32'(V_IDLE));

        // 1: basic accumulate, done in cycle 11, RB = 5 + 4*3 = 17
        run_job("t1", 8'd5, 8'd3, 4, 1'b0);
        // 2: count 0 bypasses the loop, RB = imm
        run_job("t2", 8'd5, 8'd3, 0, 1'b0);
        // 3: 100 + 200 wraps to 44
        run_job("t3", 8'd100, 8'd200, 1, 1'b0);
        // 4: full-length loop with start held throughout; exactly one job, then
        //    the held start is taken on the edge after the IDLE cycle.
        run_job("t4", 8'd0, 8'd1, 15, 1'b1);
        step();
        chk("t4_restart", 32'(obs_vec()), 32'(V_LOADA));
        dif.start = 1'b0;
        clear     = 1'b0;
        step();
        clear = 1'b1;
        chk("t4_abort", 32'(obs_vec()), 32'(V_IDLE));

        // 5: clear during the 2nd ADD aborts to IDLE, then a normal job follows
        imm       = 8'd7;
        a         = 8'd2;
        dif.count = 4'd4;
        dif.start = 1'b1;
        step();
        dif.start = 1'b0;
        for (int k = 1; k < 5; k++) step();
        chk("t5_add2", 32'(obs_vec()), 32'(V_ADD));
        clear = 1'b0;
        step();
        clear = 1'b1;
        chk("t5_cleared", 32'(obs_vec()), 32'(V_IDLE));
        run_job("t5_job", 8'd9, 8'd4, 2, 1'b0);

        // 6: random start/count/clear against a cycle-count reference
        ref_left = 0;
        ref_rb   = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (ref_left == 0) begin
                imm = 8'($urandom);
                a   = 8'($urandom);
            end
            dif.start = ($urandom_range(0, 2) == 0);
            dif.count = 4'($urandom);
            clear     = ($urandom_range(0, 49) != 0);
            st_s = dif.start;
            cl_s = clear;
            cn_s = dif.count;
            @(posedge clock);
            if (!cl_s) begin
                ref_left = 0;
            end else if (ref_left == 0) begin
                if (st_s) begin
                    ref_left = 3 + 2 * int'(cn_s);
                    tt       = int'(imm) + int'(cn_s) * int'(a);
                    ref_rb   = tt[7:0];
                end
            end else begin
                ref_left--;
            end
            #1;
            chk("rnd_excl", 32'($countones({dif.RAout, dif.RBout, dif.RZout}) <= 1), 32'd1);
            chk("rnd_busy", 32'(dif.busy), 32'(ref_left != 0));
            chk("rnd_done", 32'(dif.done), 32'(ref_left == 1));
            if (ref_left == 1) chk("rnd_rb", 32'(rb), 32'(ref_rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
